// File: rtl/noc_mem_arbiter_pkg.sv
// Shared defaults and the source-tag type used by the arbiter and the tag FIFO.
package noc_mem_arbiter_pkg;

  localparam int ARB_N_REQ   = 4;
  localparam int ARB_MAX_OUT = 4;
  localparam int ARB_IDW     = $clog2(ARB_N_REQ);

  typedef logic [ARB_IDW-1:0] arb_tag_t;

endpackage

// File: rtl/noc_mem_arbiter_if.sv
// Requester-side and memory-side channel of the arbiter, grouped as one bundle.
interface noc_mem_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    m_req_valid;
  logic                    m_req_ready;
  logic [ADDR_W-1:0]       m_addr;
  logic                    m_we;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_rsp_valid;
  logic [DATA_W-1:0]       m_rsp_data;

  // master: the requesters plus memory_interface; slave: the arbiter
  modport master (
    output req_valid, req_addr, req_we, req_wdata, m_req_ready, m_rsp_valid, m_rsp_data,
    input  req_ready, rsp_valid, rsp_data, m_req_valid, m_addr, m_we, m_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, m_req_ready, m_rsp_valid, m_rsp_data,
    output req_ready, rsp_valid, rsp_data, m_req_valid, m_addr, m_we, m_wdata
  );

endinterface

// File: rtl/noc_mem_arbiter_tag_fifo.sv
// Synchronous FIFO holding the source tag of every outstanding memory request.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/noc_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory channel between N_REQ requesters;
// responses are steered back through a FIFO of source tags.
module noc_mem_arbiter
  import noc_mem_arbiter_pkg::*;
#(
  parameter int N_REQ   = ARB_N_REQ,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = ARB_MAX_OUT
) (
  input  logic                   fclk,
  input  logic                   rst,
  noc_mem_arbiter_if.slave       bus,
  output logic                   busy,
  output logic                   err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, head_tag;
  logic [IDW:0]   pick;
  logic [CW-1:0]  fifo_count;
  logic           gnt_vld, accept, rsp_hit, fifo_full, fifo_empty;
  logic           err_q, err_d;

  // Returns {found, index}; scanning downward lets the nearest requester win.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] vld, input logic [IDW-1:0] ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (vld[IDW'(idx)]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  assign pick    = rr_pick(bus.req_valid, rr_ptr_q);
  assign gnt_vld = pick[IDW] & ~rst;
  assign gnt_idx = pick[IDW-1:0];
  assign accept  = gnt_vld & ~fifo_full & bus.m_req_ready;
  assign rsp_hit = bus.m_rsp_valid & ~fifo_empty & ~rst;

  always_comb begin
    bus.m_req_valid = gnt_vld & ~fifo_full;
    bus.m_addr      = '0;
    bus.m_we        = 1'b0;
    bus.m_wdata     = '0;
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_data    = rsp_hit ? bus.m_rsp_data : '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld && gnt_idx == IDW'(i)) begin
        bus.m_addr       = bus.req_addr[i*ADDR_W +: ADDR_W];
        bus.m_we         = bus.req_we[i];
        bus.m_wdata      = bus.req_wdata[i*DATA_W +: DATA_W];
        bus.req_ready[i] = accept;
      end
      if (rsp_hit && head_tag == IDW'(i)) bus.rsp_valid[i] = 1'b1;
    end
  end

  // Pointer only moves on accept, so a stalled grant is held
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    err_d = err_q | (bus.m_rsp_valid & fifo_empty);
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (IDW)
  ) u_tag_fifo (
    .clk   (fclk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp_hit),
    .din   (gnt_idx),
    .dout  (head_tag),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy = (fifo_count != '0);
  assign err  = err_q;

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Directed bench: request stimulus pushes expected responses; a negedge monitor checks them.
module tb_noc_mem_arbiter;
  import noc_mem_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  typedef struct packed {
    logic [NR-1:0] strobe;
    logic [DW-1:0] data;
  } exp_t;

  logic fclk = 1'b0;
  logic rst;
  logic busy, err;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  noc_mem_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  noc_mem_arbiter dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 fclk = ~fclk;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000 + AW'(i * 16);
  endfunction

  function automatic logic [DW-1:0] wd_of(input int i);
    return 128'hBEEF_0000 + DW'(i);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_we[i]             = we;
    bus.req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic expect_rsp(input int g, input logic [DW-1:0] d);
    exp_t e;
    e.strobe = NR'(1) << g;
    e.data   = d;
    sb.push_back(e);
  endtask

  // Response monitor
  always @(negedge fclk) begin
    exp_t e;
    if (bus.rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got strobe %b, want none", bus.rsp_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_strobe", DW'(bus.rsp_valid), DW'(e.strobe));
        chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_we      = '0;
    bus.req_wdata   = '0;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_data  = '0;
    for (int i = 0; i < NR; i++) set_req(i, addr_of(i), (i % 2) == 1, wd_of(i));

    // outputs forced low while reset is held, even with active inputs
    bus.req_valid   = 4'hF;
    bus.m_req_ready = 1'b1;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'h55;
    #3;
    chk("rst_req_ready", DW'(bus.req_ready), 0);
    chk("rst_m_req_valid", DW'(bus.m_req_valid), 0);
    chk("rst_m_addr", DW'(bus.m_addr), 0);
    chk("rst_rsp_valid", DW'(bus.rsp_valid), 0);
    chk("rst_busy", DW'(busy), 0);
    @(negedge fclk);
    bus.req_valid   = '0;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge fclk);
    chk("idle_busy", DW'(busy), 0);
    chk("idle_err", DW'(err), 0);
    chk("idle_m_req_valid", DW'(bus.m_req_valid), 0);
    step();

    // single read from requester 2
    set_req(2, 32'h100, 1'b0, '0);
    bus.req_valid   = 4'b0100;
    bus.m_req_ready = 1'b1;
    @(negedge fclk);
    chk("rd_req_ready", DW'(bus.req_ready), DW'(4'b0100));
    chk("rd_m_addr", DW'(bus.m_addr), DW'(32'h100));
    chk("rd_m_we", DW'(bus.m_we), 0);
    chk("rd_m_req_valid", DW'(bus.m_req_valid), 1);
    expect_rsp(2, 128'hAB);
    step();
    bus.req_valid = '0;
    @(negedge fclk);
    chk("rd_busy_pending", DW'(busy), 1);
    step();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'hAB;
    @(negedge fclk);
    step();
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("rd_busy_done", DW'(busy), 0);
    set_req(2, addr_of(2), 1'b0, wd_of(2));
    rst = 1'b1;
    #2 rst = 1'b0;
    step();

    // contention: all four valid, one response per cycle
    bus.req_valid   = 4'hF;
    bus.m_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.m_rsp_valid = (k > 0);
      bus.m_rsp_data  = 128'hD0 + DW'(k - 1);
      @(negedge fclk);
      chk("rr_req_ready", DW'(bus.req_ready), DW'(NR'(1) << (k % 4)));
      chk("rr_m_addr", DW'(bus.m_addr), DW'(addr_of(k % 4)));
      chk("rr_m_we", DW'(bus.m_we), DW'((k % 2) == 1));
      chk("rr_m_wdata", bus.m_wdata, wd_of(k % 4));
      expect_rsp(k % 4, 128'hD0 + DW'(k));
      step();
    end
    bus.req_valid   = '0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'hD4;
    @(negedge fclk);
    step();
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("rr_busy_done", DW'(busy), 0);
    step();

    // stall hold: requesters 1 and 3, memory not ready
    bus.req_valid   = 4'b1010;
    bus.m_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge fclk);
      chk("stall_m_addr", DW'(bus.m_addr), DW'(addr_of(1)));
      chk("stall_req_ready", DW'(bus.req_ready), 0);
      step();
    end
    bus.m_req_ready = 1'b1;
    @(negedge fclk);
    chk("stall_rel_req_ready", DW'(bus.req_ready), DW'(4'b0010));
    expect_rsp(1, 128'h31);
    step();
    @(negedge fclk);
    chk("stall_next_req_ready", DW'(bus.req_ready), DW'(4'b1000));
    chk("stall_next_m_addr", DW'(bus.m_addr), DW'(addr_of(3)));
    expect_rsp(3, 128'h33);
    step();
    bus.req_valid   = '0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'h31;
    @(negedge fclk);
    step();
    bus.m_rsp_data = 128'h33;
    @(negedge fclk);
    step();
    bus.m_rsp_valid = 1'b0;

    // full: four accepts, then blocked until a response has been popped
    bus.req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge fclk);
      chk("full_fill_req_ready", DW'(bus.req_ready), DW'(NR'(1) << k));
      expect_rsp(k, 128'h40 + DW'(k));
      step();
    end
    @(negedge fclk);
    chk("full_m_req_valid", DW'(bus.m_req_valid), 0);
    chk("full_req_ready", DW'(bus.req_ready), 0);
    chk("full_busy", DW'(busy), 1);
    step();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'h40;
    @(negedge fclk);
    chk("full_pop_no_accept", DW'(bus.req_ready), 0);
    chk("full_pop_m_req_valid", DW'(bus.m_req_valid), 0);
    step();
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("full_after_pop_req_ready", DW'(bus.req_ready), DW'(4'b0001));
    expect_rsp(0, 128'h44);
    step();
    @(negedge fclk);
    chk("full_again_m_req_valid", DW'(bus.m_req_valid), 0);
    step();
    bus.req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_data  = 128'h41 + DW'(j);
      @(negedge fclk);
      step();
    end
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("full_busy_done", DW'(busy), 0);
    step();

    // spurious response with nothing outstanding
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'hEE;
    @(negedge fclk);
    chk("spur_rsp_valid", DW'(bus.rsp_valid), 0);
    chk("spur_err_before", DW'(err), 0);
    step();
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("spur_err_set", DW'(err), 1);
    step();
    @(negedge fclk);
    chk("spur_err_sticky", DW'(err), 1);
    step();

    // reset mid-burst with three outstanding; rr_ptr is 1 here, so grants go 1,2,0
    bus.req_valid   = 4'b0111;
    bus.m_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge fclk);
      chk("burst_req_ready", DW'(bus.req_ready), DW'(NR'(1) << ((k + 1) % 3)));
      step();
    end
    bus.req_valid   = 4'hF;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_data  = 128'h77;
    #1 rst = 1'b1;
    #1;
    chk("arst_req_ready", DW'(bus.req_ready), 0);
    chk("arst_m_req_valid", DW'(bus.m_req_valid), 0);
    chk("arst_m_addr", DW'(bus.m_addr), 0);
    chk("arst_m_we", DW'(bus.m_we), 0);
    chk("arst_m_wdata", bus.m_wdata, 0);
    chk("arst_rsp_valid", DW'(bus.rsp_valid), 0);
    chk("arst_rsp_data", bus.rsp_data, 0);
    chk("arst_busy", DW'(busy), 0);
    chk("arst_err", DW'(err), 0);
    bus.m_rsp_valid = 1'b0;
    bus.m_req_ready = 1'b0;
    @(posedge fclk);
    #2 rst = 1'b0;
    @(negedge fclk);
    chk("post_rst_busy", DW'(busy), 0);
    chk("post_rst_err", DW'(err), 0);
    chk("post_rst_rr_ptr", DW'(bus.m_addr), DW'(addr_of(0)));
    step();
    bus.req_valid   = '0;
    bus.m_rsp_valid = 1'b1;
    @(negedge fclk);
    chk("late_rsp_valid", DW'(bus.rsp_valid), 0);
    step();
    bus.m_rsp_valid = 1'b0;
    @(negedge fclk);
    chk("late_rsp_err", DW'(err), 1);
    chk("sb_drained", DW'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_mem_arbiter.md
Name: noc_mem_arbiter

Overview:
- Shares the single memory_interface request/response channel between N_REQ requesters (cores, DMA, GPIO) on the fabric clock.
- Arbitration is round-robin. Up to MAX_OUT transactions may be outstanding.
- Responses return in order and are steered back to the issuing requester through an internal source-tag FIFO.
- Sits between the requesters' NoC-side ports and memory_interface, in soc.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_W, 32, address width.
- DATA_W, 128, data width; matches the memory data bus.
- MAX_OUT, 4, tag FIFO depth (power of two, at least 2).
- IDW, $clog2(N_REQ), source tag width (derived, not overridable).

Ports:
- fclk  in  1  fabric clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted this cycle.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i is at [i*ADDR_W +: ADDR_W].
- req_we  in  N_REQ  1 = write, 0 = read.
- req_wdata  in  N_REQ*DATA_W  packed write data.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_data  out  DATA_W  response data, shared by all requesters (read data; don't-care for write acks).
- m_req_valid  out  1  request to memory_interface.
- m_req_ready  in  1  memory_interface accepts the request.
- m_addr  out  ADDR_W  muxed address of the granted requester.
- m_we  out  1  muxed write enable of the granted requester.
- m_wdata  out  DATA_W  muxed write data of the granted requester.
- m_rsp_valid  in  1  one response from memory (read data or write ack), in request order.
- m_rsp_data  in  DATA_W  response data.
- busy  out  1  outstanding count is non-zero.
- err  out  1  sticky protocol error flag.

Behaviour:
- State registers:
  - rr_ptr (IDW bits)
  - tag FIFO (MAX_OUT x IDW) with wr_ptr, rd_ptr and count (0..MAX_OUT)
  - err
- Reset: rst high clears rr_ptr, the FIFO pointers, count and err to 0, immediately. While rst is high, every output is 0 regardless of inputs.
- Grant (combinational):
  - Search from requester rr_ptr upward, modulo N_REQ. The first i with req_valid[i]=1 is the grant.
  - No valid request means no grant.
- m_req_valid = a grant exists AND count < MAX_OUT. m_addr, m_we and m_wdata carry the granted requester's fields; they are 0 when there is no grant.
- Accept = m_req_valid & m_req_ready. req_ready[g] = accept for the granted g only; all other bits are 0.
- Zero latency: the request is accepted in the same cycle it is granted. The requester must hold valid and its fields stable until req_ready is seen.
- On accept, at the clock edge:
  - Push g into the FIFO.
  - rr_ptr <= (g+1) mod N_REQ. If N_REQ is not a power of two, wrap explicitly.
- A non-accepted cycle leaves rr_ptr unchanged, so a held grant is never stolen while memory stalls.
- Full: gating uses the registered count. With count = MAX_OUT there is no accept even if m_rsp_valid pops in the same cycle; the accept happens the following cycle.
- Response path (combinational):
  - When m_rsp_valid=1 and count>0: rsp_valid = one-hot of the FIFO head tag, rsp_data = m_rsp_data.
  - Pop the FIFO at the edge. There is no response backpressure; requesters must sink responses.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Spurious response: m_rsp_valid with count=0.
  - Drop it; rsp_valid stays 0.
  - Set err=1. err is sticky until rst.
- Pointer wrap: FIFO pointers wrap modulo MAX_OUT. count distinguishes full from empty.
- Reset mid-operation: outstanding tags are discarded. Late memory responses after reset are treated as spurious and set err. soc is required to reset memory_interface together with this block.
- busy = (count != 0).

Decomposition:
- Shared package (structs.sv / defines.sv): ARB_N_REQ and ARB_MAX_OUT defaults, plus typedef arb_tag_t (logic [IDW-1:0]).
- Sub-module tag_fifo: synchronous FIFO with parameters DEPTH and WIDTH and ports push, pop, din, dout, count, full, empty.
- Round-robin grant logic stays inline as a function.

Test Plan:
- Single read: requester 2 issues addr 0x100, m_req_ready=1.
  - Required: req_ready[2] in the same cycle, m_addr=0x100, m_we=0.
  - Memory returns data 0xAB two cycles later: rsp_valid=4'b0100, rsp_data=0xAB, then busy=0.
- Contention: all 4 requesters valid continuously, rr_ptr=0, m_req_ready=1, responses returned each cycle.
  - Required: grants in order 0,1,2,3,0.
  - Responses strobe rsp_valid 0001, 0010, 0100, 1000 in that order.
- Stall hold: requesters 1 and 3 valid, m_req_ready=0 for 5 cycles.
  - Required: m_addr stays requester 1's address throughout.
  - Once ready rises: req_ready=0010 for one cycle, then requester 3 is granted.
- Full: MAX_OUT=4 with no responses.
  - Required: exactly 4 accepts, then m_req_valid=0.
  - A response in the cycle count=4: no accept that cycle, accept the next cycle, count back to 4.
- Spurious and reset:
  - m_rsp_valid with count=0: err=1, rsp_valid=0, err stays 1 for the following cycles.
  - Assert rst asynchronously mid-burst with count=3: all outputs 0 immediately; after release count=0, rr_ptr=0, err=0.
